// File: rtl/pio_in_irq.sv
// pio_in_irq: Avalon-MM input PIO with synchroniser, optional debouncer, edge capture and interrupt
module pio_in_irq #(
  parameter int WIDTH           = 6,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0,
  parameter int IRQ_MODE        = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] s, d, d_q, edge_hit, wd;
  logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d, wr;

  // synchroniser shift chain, stage 0 takes the raw pins
  always_comb begin
    sync_d[0] = in_port;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
  end

  assign s = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES > 0) begin : g_db
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [WIDTH-1:0] db_q, db_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    // per-bit counter: a differing level is accepted once it has persisted long enough
    always_comb begin
      db_d = db_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_d[i] = '0;
        if (s[i] != db_q[i]) begin
          if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) db_d[i] = s[i];
          else cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // debouncer state
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        db_q <= '0;
        for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
        db_q <= db_d;
        for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
    end
    assign d = db_q;
  end else begin : g_nodb
    assign d = s;
  end

  // edge detect, register updates, irq source and read mux
  always_comb begin
    wr         = chipselect & ~write_n;
    wd         = writedata[WIDTH-1:0];
    edge_hit   = EDGE_TYPE == 0 ? d & ~d_q : EDGE_TYPE == 1 ? ~d & d_q : d ^ d_q;
    mask_d     = wr && address == 2'd2 ? wd : mask_q;
    cap_d      = (cap_q & ~(wr && address == 2'd3 ? wd : '0)) | edge_hit;
    irq_d      = IRQ_MODE != 0 ? |(cap_q & mask_q) : |(d & mask_q);
    readdata_d = address == 2'd0 ? 32'(d) : address == 2'd2 ? 32'(mask_q) :
                 address == 2'd3 ? 32'(cap_q) : 32'd0;
  end

  // all remaining state, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      d_q        <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
      d_q        <= d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_pio_in_irq.sv
// tb_pio_in_irq: directed checks of four pio_in_irq configurations sharing one bus
module tb_pio_in_irq;
  logic        clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write_n = 1'b1;
  logic [1:0]  address = 2'd0;
  logic [31:0] writedata = '0;
  logic [5:0]  in0 = '0, in1 = '0, in2 = '0;
  logic [31:0] in3 = 32'hDEADBEEF;
  logic [31:0] rd0, rd1, rd2, rd3;
  logic        irq0, irq1, irq2, irq3;
  int          passed = 0, total = 0;

  always #5 clk = ~clk;

  pio_in_irq u0 (.clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));
  pio_in_irq #(.DEBOUNCE_CYCLES(4)) u1 (.clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata), .in_port(in1),
    .readdata(rd1), .irq(irq1));
  pio_in_irq #(.EDGE_TYPE(2), .IRQ_MODE(0)) u2 (.clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata), .in_port(in2),
    .readdata(rd2), .irq(irq2));
  pio_in_irq #(.WIDTH(32)) u3 (.clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata), .in_port(in3),
    .readdata(rd3), .irq(irq3));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    address = a;
    writedata = v;
    chipselect = 1'b1;
    write_n = 1'b0;
    tick(1);
    write_n = 1'b1;
    chipselect = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    tick(2);
    chk("reset_rd", rd0, 32'h0);
    chk("reset_irq", {31'd0, irq0}, 32'h0);
    reset = 1'b0;
    wr(2'd2, 32'h1);
    tick(1);
    chk("mask_rb", rd0, 32'h1);
    address = 2'd3;
    in0 = 6'h01;
    tick(3);
    chk("rise_irq_early", {31'd0, irq0}, 32'h0);
    chk("rise_cap_early", rd0, 32'h0);
    tick(1);
    chk("rise_irq", {31'd0, irq0}, 32'h1);
    chk("rise_cap", rd0, 32'h01);
    wr(2'd3, 32'h1);
    chk("w1c_irq_hold", {31'd0, irq0}, 32'h1);
    tick(1);
    chk("w1c_irq_drop", {31'd0, irq0}, 32'h0);
    chk("w1c_cap", rd0, 32'h0);
    wr(2'd2, 32'h5);
    address = 2'd3;
    in0 = 6'h05;
    tick(2);
    wr(2'd3, 32'h4);
    tick(1);
    chk("set_wins_cap", rd0, 32'h04);
    chk("set_wins_irq", {31'd0, irq0}, 32'h1);
    in0 = 6'h2A;
    address = 2'd0;
    #3 reset = 1'b1;
    #1;
    chk("async_rst_rd", rd0, 32'h0);
    chk("async_rst_irq", {31'd0, irq0}, 32'h0);
    tick(1);
    reset = 1'b0;
    tick(2);
    chk("post_rst_early", rd0, 32'h0);
    tick(1);
    chk("post_rst_data", rd0, 32'h2A);
    in1 = 6'h02;
    tick(3);
    in1 = 6'h00;
    tick(8);
    chk("glitch_data", rd1, 32'h0);
    address = 2'd3;
    tick(1);
    chk("glitch_cap", rd1, 32'h0);
    address = 2'd0;
    in1 = 6'h02;
    tick(6);
    chk("db_early", rd1, 32'h0);
    tick(1);
    chk("db_data", rd1, 32'h02);
    address = 2'd3;
    tick(2);
    chk("db_cap", rd1, 32'h02);
    in2 = 6'h08;
    tick(4);
    in2 = 6'h00;
    wr(2'd3, 32'h3F);
    tick(1);
    chk("any_cleared", rd2, 32'h0);
    tick(3);
    chk("any_fall_cap", rd2, 32'h08);
    in2 = 6'h08;
    wr(2'd2, 32'h08);
    tick(3);
    chk("lvl_irq", {31'd0, irq2}, 32'h1);
    wr(2'd2, 32'h0);
    chk("lvl_irq_hold", {31'd0, irq2}, 32'h1);
    tick(1);
    chk("lvl_irq_drop", {31'd0, irq2}, 32'h0);
    wr(2'd2, 32'h12345678);
    wr(2'd0, 32'hFFFFFFFF);
    wr(2'd1, 32'hFFFFFFFF);
    address = 2'd0;
    tick(1);
    chk("w32_data", rd3, 32'hDEADBEEF);
    address = 2'd1;
    tick(1);
    chk("w32_resv", rd3, 32'h0);
    chk("w6_resv", rd0, 32'h0);
    address = 2'd2;
    tick(1);
    chk("w32_mask", rd3, 32'h12345678);
    chk("w6_mask", rd0, 32'h38);
    address = 2'd3;
    tick(1);
    chk("w32_cap", rd3, 32'hDEADBEC0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
